// File: rtl/mezcla_acondicionador_if.sv
// mezcla_acondicionador_if
// Groups the conditioner's signals toward the mixer controller side.
//   IN_raw, P1_raw, P2_raw : raw asynchronous button / level sensors
//   T                      : timer enable coming back from the controller
//   IN                     : single-cycle start pulse
//   P1, P2                 : debounced sensor levels
//   TOK                    : single-cycle timer-expiry token
//   Tcnt                   : current timer count (observation only)
// There is no valid/ready handshake on this bus: IN and TOK are one-cycle
// pulses that the consumer must sample on every rising edge of Clk, and
// P1/P2/Tcnt are plain levels valid after every edge.
// Modports: slave = the conditioner, master = whatever drives the raw
// inputs and T and consumes the outputs.
interface mezcla_acondicionador_if #(
  parameter int TMR_WIDTH = 8
) ();
  logic                 IN_raw;
  logic                 P1_raw;
  logic                 P2_raw;
  logic                 T;
  logic                 IN;
  logic                 P1;
  logic                 P2;
  logic                 TOK;
  logic [TMR_WIDTH-1:0] Tcnt;

  modport slave (
    input  IN_raw, P1_raw, P2_raw, T,
    output IN, P1, P2, TOK, Tcnt
  );

  modport master (
    output IN_raw, P1_raw, P2_raw, T,
    input  IN, P1, P2, TOK, Tcnt
  );
endinterface

// File: rtl/mezcla_acondicionador.sv
// mezcla_acondicionador
// Input conditioning and mix timer in front of the mixer controller.
// Each raw input goes through a 2-flop synchronizer and a debouncer that
// only accepts a new level after DEB_CYCLES consecutive disagreeing
// samples. The start button channel is turned into a one-cycle IN pulse on
// its debounced rising edge. The timer counts down while T is high and
// emits a one-cycle TOK every TMR_LOAD cycles, auto-reloading.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-low reset
//   io    : mezcla_acondicionador_if slave (raw inputs, T, IN/P1/P2/TOK/Tcnt)
module mezcla_acondicionador #(
  parameter int DEB_CYCLES = 4,
  parameter int TMR_WIDTH  = 8,
  parameter int TMR_LOAD   = 20
) (
  input  logic                    Clk,
  input  logic                    Reset,
  mezcla_acondicionador_if.slave  io
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]        DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] TMR_RELOAD = TMR_WIDTH'(TMR_LOAD - 1);

  // Channel index: 0 = start button, 1 = sensor P1, 2 = sensor P2.
  logic [2:0]    raw;
  logic [2:0]    s1_q;
  logic [2:0]    s2_q;
  logic [2:0]    stable_q;
  logic [2:0]    stable_d;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];

  logic                 in_pulse_q;
  logic                 in_pulse_d;
  logic                 tok_q;
  logic                 tok_d;
  logic [TMR_WIDTH-1:0] tcnt_q;
  logic [TMR_WIDTH-1:0] tcnt_d;

  assign raw = {io.P2_raw, io.P1_raw, io.IN_raw};

  // Debounce: any sample that agrees with the stable level clears the run,
  // so a glitch shorter than DEB_CYCLES never moves the output.
  always_comb begin
    stable_d = stable_q;
    for (int ch = 0; ch < 3; ch++) begin
      dcnt_d[ch] = '0;
      if (s2_q[ch] != stable_q[ch]) begin
        if (dcnt_q[ch] == DEB_LAST) begin
          stable_d[ch] = s2_q[ch];
        end else begin
          dcnt_d[ch] = dcnt_q[ch] + DW'(1);
        end
      end
    end
  end

  // Pulse is registered alongside the stable level, so IN is high in the
  // same cycle the debounced button first reads 1.
  assign in_pulse_d = stable_d[0] & ~stable_q[0];

  // Timer: dropping T discards the partial count; expiry reloads so the
  // counter never goes below zero.
  always_comb begin
    tok_d  = 1'b0;
    tcnt_d = TMR_RELOAD;
    if (io.T) begin
      if (tcnt_q == '0) begin
        tok_d  = 1'b1;
        tcnt_d = TMR_RELOAD;
      end else begin
        tcnt_d = tcnt_q - TMR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      in_pulse_q <= 1'b0;
      tok_q      <= 1'b0;
      tcnt_q     <= TMR_RELOAD;
      for (int ch = 0; ch < 3; ch++) begin
        dcnt_q[ch] <= '0;
      end
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      in_pulse_q <= in_pulse_d;
      tok_q      <= tok_d;
      tcnt_q     <= tcnt_d;
      for (int ch = 0; ch < 3; ch++) begin
        dcnt_q[ch] <= dcnt_d[ch];
      end
    end
  end

  assign io.IN   = in_pulse_q;
  assign io.P1   = stable_q[1];
  assign io.P2   = stable_q[2];
  assign io.TOK  = tok_q;
  assign io.Tcnt = tcnt_q;

endmodule

// File: tb/tb_mezcla_acondicionador.sv
// tb_mezcla_acondicionador
// Bench for mezcla_acondicionador with DEB_CYCLES=4, TMR_WIDTH=8,
// TMR_LOAD=20. Inputs are driven 1 time unit after each rising edge and
// outputs are checked 1 time unit after the following rising edge.
// Phases: a hand-derived vector table, a reset-mid-operation sequence,
// and a randomized run scored against a behavioural model.
module tb_mezcla_acondicionador;

  localparam int DEB = 4;
  localparam int TW  = 8;
  localparam int TL  = 20;
  localparam int W   = 4 + TW;

  logic Clk;
  logic Reset;

  mezcla_acondicionador_if #(.TMR_WIDTH(TW)) io ();

  mezcla_acondicionador #(
    .DEB_CYCLES (DEB),
    .TMR_WIDTH  (TW),
    .TMR_LOAD   (TL)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (io)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst_n, input logic [2:0] raw_ipp, input logic t);
    Reset     = rst_n;
    io.IN_raw = raw_ipp[2];
    io.P1_raw = raw_ipp[1];
    io.P2_raw = raw_ipp[0];
    io.T      = t;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] exp_v, input logic [W-1:0] mask);
    logic [W-1:0] act;
    act = {io.IN, io.P1, io.P2, io.TOK, io.Tcnt};
    n_cmp++;
    if ((act & mask) !== (exp_v & mask)) begin
      n_err++;
      $display("FAIL %s: got IN/P1/P2/TOK=%b Tcnt=%0d, required IN/P1/P2/TOK=%b Tcnt=%0d (mask %h)",
               name, act[W-1:W-4], act[TW-1:0], exp_v[W-1:W-4], exp_v[TW-1:0], mask);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [2:0] raw;      // {IN_raw, P1_raw, P2_raw}
    logic       t;
    int         n;        // edges this row is held
    logic       chk_tcnt;
    logic [3:0] e_flags;  // {IN, P1, P2, TOK}
    logic [7:0] e_tcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst_n, input logic [2:0] raw, input logic t, input int n,
                         input logic chk, input logic [3:0] fl, input logic [7:0] tc);
    vec_t v;
    v.rst_n = rst_n; v.raw = raw; v.t = t; v.n = n;
    v.chk_tcnt = chk; v.e_flags = fl; v.e_tcnt = tc;
    vecs.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  // Synchronized sample = raw value from two edges earlier; the level
  // flips after DEB consecutive disagreeing samples. Timer derives from
  // the length of the current run of T-high edges.
  bit pipe [3][$];
  bit stab [3];
  int run  [3];
  int trun;

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      pipe[ch].delete();
      pipe[ch].push_back(1'b0);
      pipe[ch].push_back(1'b0);
      stab[ch] = 1'b0;
      run[ch]  = 0;
    end
    trun = 0;
  endtask

  task automatic model_step(input logic rst_n, input logic [2:0] raw_ipp, input logic t);
    bit s2, prev_in, e_in, e_tok;
    bit r [3];
    int e_tcnt;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back({4'b0000, TW'(TL - 1)});
    end else begin
      r[0] = raw_ipp[2]; r[1] = raw_ipp[1]; r[2] = raw_ipp[0];
      prev_in = stab[0];
      for (int ch = 0; ch < 3; ch++) begin
        s2 = pipe[ch].pop_front();
        pipe[ch].push_back(r[ch]);
        if (s2 != stab[ch]) begin
          run[ch]++;
          if (run[ch] == DEB) begin
            stab[ch] = s2;
            run[ch]  = 0;
          end
        end else begin
          run[ch] = 0;
        end
      end
      e_in   = stab[0] && !prev_in;
      trun   = t ? trun + 1 : 0;
      e_tok  = (trun > 0) && (trun % TL == 0);
      e_tcnt = TL - 1 - (trun % TL);
      exp_q.push_back({e_in, stab[1], stab[2], e_tok, TW'(e_tcnt)});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] full, flags_only, e;
    logic cur [4];
    int   hold [4];
    logic rr;
    full       = '1;
    flags_only = {4'b1111, {TW{1'b0}}};

    drive(1'b0, 3'b000, 1'b0);

    // Reset, start pulse, glitch, P1 press/release, timer, abort, simultaneous
    add_vec(0, 3'b111, 1,  2, 1, 4'b0000, 19);
    add_vec(1, 3'b000, 0,  3, 1, 4'b0000, 19);
    add_vec(1, 3'b100, 0,  5, 1, 4'b0000, 19);
    add_vec(1, 3'b100, 0,  1, 1, 4'b1000, 19);
    add_vec(1, 3'b100, 0,  6, 1, 4'b0000, 19);
    add_vec(1, 3'b000, 0, 10, 1, 4'b0000, 19);
    add_vec(1, 3'b010, 0,  3, 1, 4'b0000, 19);
    add_vec(1, 3'b000, 0,  8, 1, 4'b0000, 19);
    add_vec(1, 3'b010, 0,  5, 1, 4'b0000, 19);
    add_vec(1, 3'b010, 0,  3, 1, 4'b0100, 19);
    add_vec(1, 3'b000, 0,  5, 1, 4'b0100, 19);
    add_vec(1, 3'b000, 0,  3, 1, 4'b0000, 19);
    add_vec(1, 3'b000, 1, 19, 0, 4'b0000,  0);
    add_vec(1, 3'b000, 1,  1, 1, 4'b0001, 19);
    add_vec(1, 3'b000, 1, 19, 0, 4'b0000,  0);
    add_vec(1, 3'b000, 1,  1, 1, 4'b0001, 19);
    add_vec(1, 3'b000, 1,  4, 0, 4'b0000,  0);
    add_vec(1, 3'b000, 1,  1, 1, 4'b0000, 14);
    add_vec(1, 3'b000, 0,  1, 1, 4'b0000, 19);
    add_vec(1, 3'b000, 1,  9, 0, 4'b0000,  0);
    add_vec(1, 3'b000, 1,  1, 1, 4'b0000,  9);
    add_vec(1, 3'b000, 0,  1, 1, 4'b0000, 19);
    add_vec(1, 3'b000, 1, 19, 0, 4'b0000,  0);
    add_vec(1, 3'b000, 1,  1, 1, 4'b0001, 19);
    add_vec(1, 3'b000, 0,  2, 1, 4'b0000, 19);
    add_vec(1, 3'b111, 0,  5, 1, 4'b0000, 19);
    add_vec(1, 3'b111, 0,  1, 1, 4'b1110, 19);
    add_vec(1, 3'b111, 0,  3, 1, 4'b0110, 19);
    add_vec(1, 3'b000, 0,  5, 1, 4'b0110, 19);
    add_vec(1, 3'b000, 0,  1, 1, 4'b0000, 19);

    tick();
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        drive(vecs[i].rst_n, vecs[i].raw, vecs[i].t);
        tick();
        check($sformatf("vec%0d.%0d", i, k), {vecs[i].e_flags, vecs[i].e_tcnt},
              vecs[i].chk_tcnt ? full : flags_only);
      end
    end

    // Reset mid-operation: Tcnt at 7 and P2 debounce run at 2, then reset.
    for (int e = 1; e <= 12; e++) begin
      drive(1'b1, (e >= 9) ? 3'b001 : 3'b000, 1'b1);
      tick();
      check($sformatf("mid_pre%0d", e), {4'b0000, TW'(TL - 1 - e)}, full);
    end
    drive(1'b0, 3'b001, 1'b1);
    tick();
    check("mid_reset", {4'b0000, TW'(TL - 1)}, full);
    for (int e = 1; e <= 25; e++) begin
      drive(1'b1, 3'b001, 1'b1);
      tick();
      check($sformatf("mid_post%0d", e),
            {1'b0, 1'b0, (e >= DEB + 2), (e % TL == 0), TW'(TL - 1 - (e % TL))}, full);
    end

    // Randomized run against the model
    for (int i = 0; i < 4; i++) begin
      cur[i]  = 1'b0;
      hold[i] = 0;
    end
    drive(1'b0, 3'b000, 1'b0);
    model_step(1'b0, 3'b000, 1'b0);
    tick();
    e = exp_q.pop_front();
    check("rnd_reset", e, full);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = ~cur[i];
          hold[i] = (i == 3) ? $urandom_range(1, 45) : $urandom_range(1, 9);
        end
        hold[i]--;
      end
      rr = ($urandom_range(0, 299) != 0);
      drive(rr, {cur[0], cur[1], cur[2]}, cur[3]);
      model_step(rr, {cur[0], cur[1], cur[2]}, cur[3]);
      tick();
      e = exp_q.pop_front();
      check($sformatf("rnd%0d", cyc), e, full);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mezcla_acondicionador.md
# mezcla_acondicionador

Input-conditioning and timing stage that sits directly upstream of the mixer controller FSM. It synchronizes and debounces the raw start push-button and the two level sensors, turning the button into a single-cycle start pulse. It also hosts the mix timer, which turns the controller's timer-enable `T` into `TOK` tokens. Outputs `IN`, `P1`, `P2` and `TOK` connect straight to the mixer controller inputs of the same names, and its `T` output feeds back here.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable cycles required before a debounced output changes; legal range ≥ 1.
- `TMR_WIDTH`, default 8: width of the timer counter.
- `TMR_LOAD`, default 20: timer period in cycles; legal range 2 .. 2^TMR_WIDTH.

Ports (reset `Reset` is synchronous and active-low; clock `Clk`):
- `Clk`  in  1: system clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-low reset.
- `IN_raw`  in  1: asynchronous start push-button, active-high.
- `P1_raw`  in  1: asynchronous level sensor 1.
- `P2_raw`  in  1: asynchronous level sensor 2.
- `T`  in  1: timer enable from the mixer controller, synchronous to `Clk`.
- `IN`  out  1: single-cycle start pulse.
- `P1`  out  1: debounced level of sensor 1.
- `P2`  out  1: debounced level of sensor 2.
- `TOK`  out  1: single-cycle timer-expiry token.
- `Tcnt`  out  `TMR_WIDTH`: current timer count, for observation.

## Operation
- **Reset** (edge with `Reset` = 0):
  - all synchronizer flops, stable values and debounce counters go to 0;
  - `IN`, `P1`, `P2` and `TOK` go to 0;
  - `Tcnt` goes to `TMR_LOAD` − 1;
  - `Reset` dominates every other condition at that edge.
- **Synchronizer:** each raw input passes through a 2-flop chain (`s1`, then `s2`).
- **Debounce counter:** one `dcnt` per channel, width ceil(log2(`DEB_CYCLES`)) with a minimum of 1.
  - If `s2` equals the stable value: `dcnt` ← 0.
  - If `s2` differs and `dcnt` = `DEB_CYCLES` − 1: stable ← `s2`, `dcnt` ← 0.
  - If `s2` differs otherwise: `dcnt` ← `dcnt` + 1.
- **Outputs:**
  - `P1` and `P2` are the stable values of their channels.
  - `IN` is high for exactly one cycle, following the edge where the IN stable value goes 0→1.
  - The IN channel's 1→0 transition produces no pulse.
  - Holding the button produces no further pulses.
- **Timer:**
  - `T` = 0: `Tcnt` ← `TMR_LOAD` − 1, `TOK` ← 0.
  - `T` = 1 and `Tcnt` = 0: `TOK` ← 1, `Tcnt` ← `TMR_LOAD` − 1 (auto-reload).
  - `T` = 1 and `Tcnt` ≠ 0: `Tcnt` ← `Tcnt` − 1, `TOK` ← 0.
- **Arithmetic:** unsigned. `Tcnt` never wraps below 0; expiry always reloads it.

## Timing
- **Debounce latency:**
  - A raw change held stable is reflected on `P1`/`P2` after exactly 2 + `DEB_CYCLES` rising edges.
  - The first mismatch edge is edge 3.
  - Pulses shorter than `DEB_CYCLES` cycles (after synchronization) are fully rejected, and the counter restarts from 0.
- **IN pulse:** `IN` rises after edge 2 + `DEB_CYCLES` following the press and falls after the next edge.
- **Timer:**
  - With `T` first sampled high at edge k and held, `TOK` is high in the cycles following edges k + `TMR_LOAD` − 1, k + 2·`TMR_LOAD` − 1, and so on.
  - Each `TOK` pulse is 1 cycle wide, with a period of `TMR_LOAD`.
- **`T` deasserted mid-count:** `TOK` is not asserted and the count is discarded. Re-asserting `T` starts a full `TMR_LOAD` period.
- **`T` falling at the expiry edge:** if `T` = 0 at the edge where `Tcnt` would reach the `TOK` condition, `TOK` stays 0.
- **Simultaneous changes:** simultaneous raw-input changes are handled independently per channel, with no cross-channel priority.
- **Reset mid-operation:** a reset during debounce or count abandons all progress. Outputs reach their reset values after that edge.

## Test plan
- **Reset:** hold `Reset` = 0 for 2 cycles with all raw inputs at 1 and `T` = 1 → `IN` = `P1` = `P2` = `TOK` = 0 and `Tcnt` = 19, throughout and after the reset edges.
- **Start pulse:** `DEB_CYCLES` = 4, `IN_raw` high for 12 cycles → exactly one `IN` pulse, high after edge 6; no pulse on release.
- **Glitch rejection and release:** `P1_raw` high for 3 cycles → `P1` stays 0. `P1_raw` high for 8 cycles → `P1` = 1 after edge 6 and returns to 0 six edges after release.
- **Periodic tokens:** `TMR_LOAD` = 20, `T` held high for 45 cycles → `TOK` 1-cycle pulses after edges 20 and 40 (counting edge 1 as the first with `T` sampled high), and `Tcnt` reloads to 19 on each.
- **Timer abort and restart:** `T` high for 10 cycles, low for 1, high again → no `TOK` from the first run; `TOK` follows 20 edges after the re-assertion.
- **Reset mid-operation:** `Reset` = 0 while `Tcnt` = 7 and P2's debounce counter is at 2 → after that edge `Tcnt` = 19 and `P2` = 0. After release, `P2` needs the full 6-edge latency and the timer the full 20 edges.
